// File: rtl/weight_mem_fifo_control.sv
// Streams one weight submatrix from weight memory into the weight FIFOs, one row per cycle.
// Rows beyond the valid matrix height are pushed as zeros so the FIFOs always get width_height rows.
module weight_mem_fifo_control #(
    parameter int width_height = 16,
    parameter int data_width   = width_height * 8,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            weight_mem_fifo_en,
    input  logic [ADDR_WIDTH-1:0]           base_addr,
    input  logic [$clog2(width_height):0]   num_row_weight_mat,
    input  logic                            fifo_full,
    input  logic [data_width-1:0]           weight_mem_rd_data,
    output logic                            weight_mem_rd_en,
    output logic [ADDR_WIDTH-1:0]           weight_mem_addr,
    output logic                            fifo_wr_en,
    output logic [data_width-1:0]           fifo_wr_data,
    output logic [$clog2(width_height)-1:0] fifo_wr_row,
    output logic                            weight_mem_fifo_done
);

    localparam int RW = $clog2(width_height);
    localparam int NW = RW + 1;

    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, DONE, RELEASE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [NW-1:0]         n_q, n_d;
    logic [RW-1:0]         r_q, r_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  slot_q, slot_d;
    logic                  slot_zero_q, slot_zero_d;
    logic [RW-1:0]         slot_row_q, slot_row_d;
    logic                  wr_en_q, wr_en_d;
    logic                  wr_zero_q, wr_zero_d;
    logic [RW-1:0]         wr_row_q, wr_row_d;
    logic                  done_q, done_d;
    logic                  abort;

    assign abort = ((state_q == LOAD) || (state_q == DRAIN)) && !weight_mem_fifo_en;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        n_d         = n_q;
        r_d         = r_q;
        rd_en_d     = 1'b0;
        addr_d      = addr_q;
        slot_d      = 1'b0;
        slot_zero_d = 1'b0;
        slot_row_d  = slot_row_q;
        done_d      = 1'b0;
        // The slot issued last cycle becomes a write now unless the load is being aborted.
        wr_en_d     = slot_q && !abort;
        wr_zero_d   = slot_zero_q;
        wr_row_d    = slot_row_q;

        case (state_q)
            IDLE: begin
                if (weight_mem_fifo_en) begin
                    base_d  = base_addr;
                    n_d     = (num_row_weight_mat > NW'(width_height)) ? NW'(width_height)
                                                                       : num_row_weight_mat;
                    r_d     = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (!weight_mem_fifo_en) begin
                    state_d = IDLE;
                end else if (!fifo_full) begin
                    slot_d     = 1'b1;
                    slot_row_d = r_q;
                    if ({1'b0, r_q} < n_q) begin
                        rd_en_d = 1'b1;
                        addr_d  = base_q + ADDR_WIDTH'(r_q);
                    end else begin
                        slot_zero_d = 1'b1;
                    end
                    if (r_q == RW'(width_height - 1)) begin
                        state_d = DRAIN;
                    end else begin
                        r_d = r_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                state_d = weight_mem_fifo_en ? DONE : IDLE;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = RELEASE;
            end
            RELEASE: begin
                // Hold here until en drops so a still-high request cannot retrigger a load.
                if (!weight_mem_fifo_en) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            base_q      <= '0;
            n_q         <= '0;
            r_q         <= '0;
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
            slot_q      <= 1'b0;
            slot_zero_q <= 1'b0;
            slot_row_q  <= '0;
            wr_en_q     <= 1'b0;
            wr_zero_q   <= 1'b0;
            wr_row_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            n_q         <= n_d;
            r_q         <= r_d;
            rd_en_q     <= rd_en_d;
            addr_q      <= addr_d;
            slot_q      <= slot_d;
            slot_zero_q <= slot_zero_d;
            slot_row_q  <= slot_row_d;
            wr_en_q     <= wr_en_d;
            wr_zero_q   <= wr_zero_d;
            wr_row_q    <= wr_row_d;
            done_q      <= done_d;
        end
    end

    assign weight_mem_rd_en     = rd_en_q;
    assign weight_mem_addr      = addr_q;
    assign fifo_wr_en           = wr_en_q;
    // Memory data arrives the cycle after the read strobe and is forwarded straight to the FIFO.
    assign fifo_wr_data         = (wr_en_q && !wr_zero_q) ? weight_mem_rd_data : '0;
    assign fifo_wr_row          = wr_row_q;
    assign weight_mem_fifo_done = done_q;

endmodule

// File: tb/tb_weight_mem_fifo_control.sv
// Scoreboard bench: expected reads/writes are queued when a load is started and
// matched against the DUT's memory reads and FIFO pushes as they appear.
module tb_weight_mem_fifo_control;

    localparam int H  = 16;
    localparam int DW = H * 8;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic [AW-1:0] base;
    logic [4:0]    num;
    logic          full;
    logic [DW-1:0] rd_data;
    logic          rd_en;
    logic [AW-1:0] addr;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic [3:0]    wr_row;
    logic          done;

    weight_mem_fifo_control #(.width_height(H), .data_width(DW), .ADDR_WIDTH(AW)) dut (
        .clk                 (clk),
        .reset               (reset),
        .weight_mem_fifo_en  (en),
        .base_addr           (base),
        .num_row_weight_mat  (num),
        .fifo_full           (full),
        .weight_mem_rd_data  (rd_data),
        .weight_mem_rd_en    (rd_en),
        .weight_mem_addr     (addr),
        .fifo_wr_en          (wr_en),
        .fifo_wr_data        (wr_data),
        .fifo_wr_row         (wr_row),
        .weight_mem_fifo_done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int rd_cnt = 0;

    logic [AW-1:0] exp_addr[$];
    logic [3:0]    exp_row[$];
    logic [DW-1:0] exp_data[$];

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        for (int i = 0; i < H; i++) w[i*8 +: 8] = a + 8'(i * 37);
        return w;
    endfunction

    // Weight memory with one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem_word(addr);
    end

    always @(posedge clk) begin
        #1;
        cyc++;
        if (rd_en) begin
            rd_cnt++;
            $display("cyc %0d read addr %h", cyc, addr);
            if (exp_addr.size() == 0) check("rd_unexpected", 1, 0);
            else check("rd_addr", addr, exp_addr.pop_front());
        end
        if (wr_en) begin
            $display("cyc %0d write row %0d data %h", cyc, wr_row, wr_data);
            if (exp_row.size() == 0) check("wr_unexpected", 1, 0);
            else begin
                check("wr_row", wr_row, exp_row.pop_front());
                check("wr_data", wr_data, exp_data.pop_front());
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            $display("cyc %0d done", cyc);
        end
    end

    task automatic push_exp(input int b, input int n, input int max_reads, input int max_writes);
        int nv;
        logic [AW-1:0] a;
        nv = (n > H) ? H : n;
        for (int r = 0; r < H; r++) begin
            a = AW'(b + r);
            if (r < nv && r < max_reads) exp_addr.push_back(a);
            if (r < max_writes) begin
                exp_row.push_back(4'(r));
                exp_data.push_back((r < nv) ? mem_word(a) : '0);
            end
        end
    endtask

    task automatic run_load(input int b, input int n, input int stall_s, input int stall_len,
                            input int exp_done);
        int start, d0, rc, rel;
        @(negedge clk);
        en = 1'b1;
        base = AW'(b);
        num = 5'(n);
        start = cyc + 1;
        d0 = done_cnt;
        push_exp(b, n, H, H);
        for (int k = 0; k < 80 && done_cnt == d0; k++) begin
            @(negedge clk);
            rel = cyc - start + 1;
            full = (rel >= stall_s) && (rel < stall_s + stall_len);
        end
        full = 1'b0;
        check("done_seen", 32'(done_cnt - d0), 1);
        check("done_cycle", 32'(done_cyc - start), 32'(exp_done));
        check("rows_left", 32'(exp_row.size()), 0);
        check("reads_left", 32'(exp_addr.size()), 0);
        rc = rd_cnt;
        repeat (6) @(negedge clk);
        check("retrig_reads", 32'(rd_cnt - rc), 0);
        check("retrig_done", 32'(done_cnt - d0), 1);
        en = 1'b0;
        @(negedge clk);
        exp_addr.delete();
        exp_row.delete();
        exp_data.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_addr"}, addr, 0);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_wr_row"}, wr_row, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        int start, d0;
        reset = 1'b1;
        en = 1'b0;
        full = 1'b0;
        base = '0;
        num = '0;
        rd_data = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        run_load(8'h10, 16, 0, 0, 18);
        run_load(8'h20, 5, 0, 0, 18);
        run_load(8'h50, 16, 4, 3, 21);
        run_load(8'hFE, 4, 0, 0, 18);
        run_load(8'h60, 0, 0, 0, 18);
        run_load(8'h70, 20, 0, 0, 18);

        // Abort: en low at cycle 7 kills the in-flight write and the done pulse.
        @(negedge clk);
        en = 1'b1; base = 8'h30; num = 5'd16;
        start = cyc + 1;
        d0 = done_cnt;
        push_exp(8'h30, 16, 6, 5);
        while (cyc - start + 1 < 7) @(negedge clk);
        en = 1'b0;
        repeat (25) @(negedge clk);
        check("abort_rows_left", 32'(exp_row.size()), 0);
        check("abort_reads_left", 32'(exp_addr.size()), 0);
        check("abort_done", 32'(done_cnt - d0), 0);
        exp_addr.delete(); exp_row.delete(); exp_data.delete();

        // Reset at cycle 9 of a load while en stays high.
        @(negedge clk);
        en = 1'b1; base = 8'h40; num = 5'd16;
        start = cyc + 1;
        d0 = done_cnt;
        push_exp(8'h40, 16, 8, 7);
        while (cyc - start + 1 < 9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_outputs_zero("midrst");
        @(negedge clk);
        check_outputs_zero("midrst2");
        check("midrst_rows_left", 32'(exp_row.size()), 0);
        check("midrst_reads_left", 32'(exp_addr.size()), 0);
        check("midrst_done", 32'(done_cnt - d0), 0);
        exp_addr.delete(); exp_row.delete(); exp_data.delete();
        reset = 1'b0;
        en = 1'b0;
        @(negedge clk);
        run_load(8'h80, 16, 0, 0, 18);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
